// File: rtl/regfile_sb_if.sv
// Write-back / issue / read-side bundle for the regfile_sb architectural state holder.
// master = pipeline side (write-back, issue, read/execute), slave = register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 12
);
  logic [3:0]        rd_addr_a;
  logic [3:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] lr_rdata;
  logic [3:0]        flags_rdata;
  logic [3:0]        reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic [DATA_W-1:0] lr_wdata;
  logic              lr_we;
  logic [3:0]        flag_wdata;
  logic              flag_we;
  logic              claim_we;
  logic [3:0]        claim_addr;
  logic              claim_lr;
  logic              claim_ready;
  logic              busy_a;
  logic              busy_b;
  logic              busy_lr;
  logic              sb_err;

  modport master (
    output rd_addr_a, rd_addr_b, reg_waddr, reg_wdata, reg_we,
           lr_wdata, lr_we, flag_wdata, flag_we, claim_we, claim_addr, claim_lr,
    input  rd_data_a, rd_data_b, lr_rdata, flags_rdata, claim_ready,
           busy_a, busy_b, busy_lr, sb_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, reg_waddr, reg_wdata, reg_we,
           lr_wdata, lr_we, flag_wdata, flag_we, claim_we, claim_addr, claim_lr,
    output rd_data_a, rd_data_b, lr_rdata, flags_rdata, claim_ready,
           busy_a, busy_b, busy_lr, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// 16 GPRs + LR + flags with a per-register pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-through forwarding of data and busy release.
module regfile_sb #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned PEND_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int unsigned NREG = 16;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] lr_q;
  logic [3:0]        flags_q;
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [PEND_W-1:0] lr_cnt_q;
  logic [PEND_W-1:0] lr_cnt_d;
  logic              sb_err_q;
  logic              sb_err_d;

  logic              claim_ready_c;
  logic [NREG-1:0]   inc_v;
  logic [NREG-1:0]   dec_v;
  logic              lr_inc;

  // A claim is only accepted when every counter it touches has headroom
  assign claim_ready_c = (cnt_q[bus.claim_addr] != CNT_MAX) &&
                         (!bus.claim_lr || (lr_cnt_q != CNT_MAX));
  assign inc_v  = (bus.claim_we && claim_ready_c) ? (NREG'(1) << bus.claim_addr) : '0;
  assign dec_v  = bus.reg_we ? (NREG'(1) << bus.reg_waddr) : '0;
  assign lr_inc = bus.claim_lr && claim_ready_c;

  // Scoreboard next state; a same-register claim and write-back cancel out
  always_comb begin
    cnt_d    = cnt_q;
    lr_cnt_d = lr_cnt_q;
    sb_err_d = sb_err_q;
    if ((bus.claim_we || bus.claim_lr) && !claim_ready_c) sb_err_d = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == '0) sb_err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    if (lr_inc && !bus.lr_we) begin
      lr_cnt_d = lr_cnt_q + CNT_ONE;
    end else if (bus.lr_we && !lr_inc) begin
      if (lr_cnt_q == '0) sb_err_d = 1'b1;
      else                lr_cnt_d = lr_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      lr_q     <= '0;
      flags_q  <= '0;
      lr_cnt_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (bus.reg_we)  gpr_q[bus.reg_waddr] <= bus.reg_wdata;
      if (bus.lr_we)   lr_q    <= bus.lr_wdata;
      if (bus.flag_we) flags_q <= bus.flag_wdata;
      cnt_q    <= cnt_d;
      lr_cnt_q <= lr_cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = bus.reg_we && (bus.reg_waddr == bus.rd_addr_a);
  assign fwd_b = bus.reg_we && (bus.reg_waddr == bus.rd_addr_b);

  assign bus.rd_data_a   = fwd_a ? bus.reg_wdata : gpr_q[bus.rd_addr_a];
  assign bus.rd_data_b   = fwd_b ? bus.reg_wdata : gpr_q[bus.rd_addr_b];
  assign bus.lr_rdata    = bus.lr_we ? bus.lr_wdata : lr_q;
  assign bus.flags_rdata = bus.flag_we ? bus.flag_wdata : flags_q;
  // The last outstanding write landing this cycle releases the source early
  assign bus.busy_a  = (cnt_q[bus.rd_addr_a] != '0) && !(fwd_a && (cnt_q[bus.rd_addr_a] == CNT_ONE));
  assign bus.busy_b  = (cnt_q[bus.rd_addr_b] != '0) && !(fwd_b && (cnt_q[bus.rd_addr_b] == CNT_ONE));
  assign bus.busy_lr = (lr_cnt_q != '0) && !(bus.lr_we && (lr_cnt_q == CNT_ONE));
`else
  assign bus.rd_data_a   = gpr_q[bus.rd_addr_a];
  assign bus.rd_data_b   = gpr_q[bus.rd_addr_b];
  assign bus.lr_rdata    = lr_q;
  assign bus.flags_rdata = flags_q;
  assign bus.busy_a      = (cnt_q[bus.rd_addr_a] != '0);
  assign bus.busy_b      = (cnt_q[bus.rd_addr_b] != '0);
  assign bus.busy_lr     = (lr_cnt_q != '0);
`endif

  assign bus.claim_ready = claim_ready_c;
  assign bus.sb_err      = sb_err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a reference model predicts every output each cycle.
module tb_regfile_sb;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned PEND_W = 3;
  localparam int CNT_MAX = (1 << PEND_W) - 1;

  logic clk;
  logic rst;
  regfile_sb_if #(.DATA_W(DATA_W)) bus();
  regfile_sb #(.DATA_W(DATA_W), .PEND_W(PEND_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] gpr_m [16];
  logic [DATA_W-1:0] lr_m;
  logic [3:0]        flags_m;
  int                cnt_m [16];
  int                lr_cnt_m;
  bit                err_m;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.reg_we = 1'b0; bus.reg_waddr = '0; bus.reg_wdata = '0;
    bus.lr_we = 1'b0;  bus.lr_wdata = '0;
    bus.flag_we = 1'b0; bus.flag_wdata = '0;
    bus.claim_we = 1'b0; bus.claim_addr = '0; bus.claim_lr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin gpr_m[i] = '0; cnt_m[i] = 0; end
    lr_m = '0; flags_m = '0; lr_cnt_m = 0; err_m = 1'b0;
  endtask

  // Predict combinational outputs for the inputs currently driven
  task automatic push_expect();
    int ra, rb, ca;
    logic [DATA_W-1:0] ea, eb, elr;
    logic [3:0] ef;
    bit ba, bb, blr, rdy;
    ra = int'(bus.rd_addr_a); rb = int'(bus.rd_addr_b); ca = int'(bus.claim_addr);
    ea = gpr_m[ra]; eb = gpr_m[rb]; elr = lr_m; ef = flags_m;
    ba = (cnt_m[ra] != 0); bb = (cnt_m[rb] != 0); blr = (lr_cnt_m != 0);
`ifdef REGFILE_BYPASS_EN
    if (bus.reg_we && bus.reg_waddr == bus.rd_addr_a) begin ea = bus.reg_wdata; if (cnt_m[ra] == 1) ba = 1'b0; end
    if (bus.reg_we && bus.reg_waddr == bus.rd_addr_b) begin eb = bus.reg_wdata; if (cnt_m[rb] == 1) bb = 1'b0; end
    if (bus.lr_we) begin elr = bus.lr_wdata; if (lr_cnt_m == 1) blr = 1'b0; end
    if (bus.flag_we) ef = bus.flag_wdata;
`endif
    rdy = (cnt_m[ca] < CNT_MAX) && (!bus.claim_lr || lr_cnt_m < CNT_MAX);
    tag_q.push_back("rd_data_a");   exp_q.push_back(32'(ea));
    tag_q.push_back("rd_data_b");   exp_q.push_back(32'(eb));
    tag_q.push_back("busy_a");      exp_q.push_back(32'(ba));
    tag_q.push_back("busy_b");      exp_q.push_back(32'(bb));
    tag_q.push_back("busy_lr");     exp_q.push_back(32'(blr));
    tag_q.push_back("claim_ready"); exp_q.push_back(32'(rdy));
    tag_q.push_back("lr_rdata");    exp_q.push_back(32'(elr));
    tag_q.push_back("flags_rdata"); exp_q.push_back(32'(ef));
    tag_q.push_back("sb_err");      exp_q.push_back(32'(err_m));
  endtask

  task automatic check_outputs();
    logic [31:0] act [9];
    act[0] = 32'(bus.rd_data_a); act[1] = 32'(bus.rd_data_b);
    act[2] = 32'(bus.busy_a);    act[3] = 32'(bus.busy_b);
    act[4] = 32'(bus.busy_lr);   act[5] = 32'(bus.claim_ready);
    act[6] = 32'(bus.lr_rdata);  act[7] = 32'(bus.flags_rdata);
    act[8] = 32'(bus.sb_err);
    for (int i = 0; i < 9; i++) chk(tag_q.pop_front(), act[i], exp_q.pop_front());
  endtask

  // Rising-edge state update of the reference model
  task automatic model_clock();
    int ca, wa;
    bit rdy, ci, cl;
    ca = int'(bus.claim_addr); wa = int'(bus.reg_waddr);
    rdy = (cnt_m[ca] < CNT_MAX) && (!bus.claim_lr || lr_cnt_m < CNT_MAX);
    if ((bus.claim_we || bus.claim_lr) && !rdy) err_m = 1'b1;
    ci = bus.claim_we && rdy;
    cl = bus.claim_lr && rdy;
    if (!(ci && bus.reg_we && ca == wa)) begin
      if (ci) cnt_m[ca]++;
      if (bus.reg_we) begin
        if (cnt_m[wa] == 0) err_m = 1'b1;
        else cnt_m[wa]--;
      end
    end
    if (!(cl && bus.lr_we)) begin
      if (cl) lr_cnt_m++;
      if (bus.lr_we) begin
        if (lr_cnt_m == 0) err_m = 1'b1;
        else lr_cnt_m--;
      end
    end
    if (bus.reg_we)  gpr_m[wa] = bus.reg_wdata;
    if (bus.lr_we)   lr_m = bus.lr_wdata;
    if (bus.flag_we) flags_m = bus.flag_wdata;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic run_cycle();
    push_expect();
    #2;
    check_outputs();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    model_reset();
    push_expect();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic claim(input logic [3:0] a);
    idle(); bus.claim_we = 1'b1; bus.claim_addr = a; bus.rd_addr_a = a; run_cycle();
  endtask

  task automatic wb(input logic [3:0] a, input logic [DATA_W-1:0] d);
    idle(); bus.reg_we = 1'b1; bus.reg_waddr = a; bus.reg_wdata = d; bus.rd_addr_a = a; run_cycle();
  endtask

  task automatic look(input logic [3:0] a);
    idle(); bus.rd_addr_a = a; run_cycle();
  endtask

  initial begin
    rst = 1'b0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    idle();
    #1;
    model_reset();
    push_expect();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Reset state of every register
    for (int i = 0; i < 8; i++) begin
      idle(); bus.rd_addr_a = 4'(2 * i); bus.rd_addr_b = 4'(2 * i + 1); run_cycle();
    end

    // Plain write and read-back, flags alongside
    idle(); bus.reg_we = 1'b1; bus.reg_waddr = 4'd5; bus.reg_wdata = 12'hABC;
    bus.flag_we = 1'b1; bus.flag_wdata = 4'hA; bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd5;
    run_cycle();
    look(4'd5);

    // Two claims on r3 need two write-backs
    claim(4'd3); claim(4'd3);
    wb(4'd3, 12'h111); look(4'd3);
    wb(4'd3, 12'h222); look(4'd3);

    // Claim and write-back to r2 in one cycle leaves the count at 1
    claim(4'd2);
    idle(); bus.claim_we = 1'b1; bus.claim_addr = 4'd2;
    bus.reg_we = 1'b1; bus.reg_waddr = 4'd2; bus.reg_wdata = 12'h0F0; bus.rd_addr_a = 4'd2;
    run_cycle();
    look(4'd2);
    wb(4'd2, 12'h0F1); look(4'd2);

    // Unclaimed LR write-back: data lands, error latches
    idle(); bus.lr_we = 1'b1; bus.lr_wdata = 12'h5A5; run_cycle();
    look(4'd0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      idle();
      bus.rd_addr_a  = 4'($urandom_range(0, 15));
      bus.rd_addr_b  = 4'($urandom_range(0, 15));
      bus.claim_we   = 1'($urandom_range(0, 1));
      bus.claim_addr = 4'($urandom_range(0, 15));
      bus.claim_lr   = ($urandom_range(0, 3) == 0);
      bus.reg_we     = 1'($urandom_range(0, 1));
      bus.reg_waddr  = 4'($urandom_range(0, 15));
      bus.reg_wdata  = 12'($urandom);
      bus.lr_we      = ($urandom_range(0, 3) == 0);
      bus.lr_wdata   = 12'($urandom);
      bus.flag_we    = 1'($urandom_range(0, 1));
      bus.flag_wdata = 4'($urandom);
      run_cycle();
    end

    // Asynchronous reset with claims outstanding
    do_reset();
    claim(4'd1); claim(4'd4);
    idle(); bus.claim_we = 1'b1; bus.claim_addr = 4'd9; bus.claim_lr = 1'b1; run_cycle();
    idle(); bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd4;
    push_expect();
    #2;
    check_outputs();
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    push_expect();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(); bus.rd_addr_a = 4'(2 * i); bus.rd_addr_b = 4'(2 * i + 1); run_cycle();
    end
    idle(); bus.reg_we = 1'b1; bus.reg_waddr = 4'd9; bus.reg_wdata = 12'h099; bus.rd_addr_a = 4'd9;
    run_cycle();
    look(4'd9);

    // Saturation of r7: seventh claim fills it, eighth is dropped
    do_reset();
    for (int i = 0; i < CNT_MAX; i++) claim(4'd7);
    claim(4'd7);
    look(4'd7);
    for (int i = 0; i < CNT_MAX; i++) wb(4'd7, 12'(12'h700 + i));
    look(4'd7);

    // LR claim then write-back, no error
    do_reset();
    idle(); bus.claim_lr = 1'b1; run_cycle();
    idle(); bus.lr_we = 1'b1; bus.lr_wdata = 12'h3C3; run_cycle();
    look(4'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
